// File: rtl/price_text_pkg.sv
// Shared definitions for the price-text path: the encoder FSM state encoding,
// font character codes used for the text buffer, and the BCD digit width.
package price_text_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [6:0] CHAR_ZERO  = 7'h30;
   localparam logic [6:0] CHAR_SPACE = 7'h20;
   localparam int         DIGIT_W    = 4;

endpackage

// File: rtl/bcd_add3_stage.sv
// Double-dabble correction stage: every BCD nibble holding 5 or more gets 3
// added so that the following left shift carries correctly into the next
// decimal digit. Purely combinational; a nibble never exceeds 9 before the
// shift, so the 4-bit add never carries out.
module bcd_add3_stage
   import price_text_pkg::*;
#(
   parameter int NDIG = 5
) (
   input  logic [DIGIT_W*NDIG-1:0] i_bcd,
   output logic [DIGIT_W*NDIG-1:0] o_bcd
);

   // Correct each nibble independently before the next shift
   always_comb begin
      o_bcd = i_bcd;
      for (int d = 0; d < NDIG; d++) begin
         if (i_bcd[d*DIGIT_W +: DIGIT_W] >= 4'd5) begin
            o_bcd[d*DIGIT_W +: DIGIT_W] = i_bcd[d*DIGIT_W +: DIGIT_W] + 4'd3;
         end
      end
   end

endmodule

// File: rtl/price_char_encoder.sv
// Binary price to decimal text encoder. Saturates the input at MAX_VAL,
// converts it with a bit-serial double-dabble (one bit per cycle), then
// writes NDIG character cells into the text buffer, most-significant first.
// Optional build macro LEAD_ZERO_BLANK_EN: leading zero digits are written
// as spaces; the least-significant digit is always a numeral.
module price_char_encoder
   import price_text_pkg::*;
#(
   parameter int                PRICE_W   = 17,
   parameter int                NDIG      = 5,
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 8'd0,
   parameter int                MAX_VAL   = 99999
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    start,
   input  logic [PRICE_W-1:0]      price_bin,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic [DIGIT_W*NDIG-1:0] bcd_out,
   output logic                    wr_en,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [6:0]              wr_char
);

   localparam int BCD_W = DIGIT_W * NDIG;
   localparam int CNT_W = (PRICE_W > 1) ? $clog2(PRICE_W) : 1;
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t               r_state;
   state_t               w_nextState;
   logic                 w_accept;
   logic [PRICE_W-1:0]   r_operand;
   logic [BCD_W-1:0]     r_bcd;
   logic [BCD_W-1:0]     w_adjBcd;
   logic [BCD_W-1:0]     r_bcdOut;
   logic [CNT_W-1:0]     r_bitCnt;
   logic [IDX_W-1:0]     r_index;
   logic                 r_overflow;
   logic [DIGIT_W-1:0]   w_digit;
   logic [6:0]           w_cellChar;
`ifdef LEAD_ZERO_BLANK_EN
   logic                 r_seenNonZero;
`endif

   bcd_add3_stage #(
      .NDIG (NDIG)
   ) u_add3 (
      .i_bcd (r_bcd),
      .o_bcd (w_adjBcd)
   );

   assign overflow = r_overflow;
   assign bcd_out  = r_bcdOut;

   // State register; reset aborts any conversion in flight
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Pick out the digit addressed by the current write index
   always_comb begin
      w_digit = '0;
      for (int d = 0; d < NDIG; d++) begin
         if (r_index == IDX_W'(d)) begin
            w_digit = r_bcd[d*DIGIT_W +: DIGIT_W];
         end
      end
   end

   // Character for the current cell, blanking leading zeros when enabled
   always_comb begin
      w_cellChar = CHAR_ZERO + {3'b000, w_digit};
`ifdef LEAD_ZERO_BLANK_EN
      if (!r_seenNonZero && (w_digit == '0) && (r_index != '0)) begin
         w_cellChar = CHAR_SPACE;
      end
`endif
   end

   // Next-state logic and the handshake/write-port outputs decoded from state
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = BASE_ADDR;
      wr_char     = CHAR_SPACE;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_nextState = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (r_bitCnt == '0) begin
               w_nextState = WRITE;
            end
         end
         WRITE: begin
            busy    = 1'b1;
            wr_en   = 1'b1;
            wr_addr = BASE_ADDR + ADDR_W'(NDIG - 1) - ADDR_W'(r_index);
            wr_char = w_cellChar;
            if (r_index == '0) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            done        = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Conversion datapath: latch the saturated operand, shift it through the
   // BCD accumulator, then step the write index down and publish the result
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_operand     <= '0;
         r_bcd         <= '0;
         r_bcdOut      <= '0;
         r_bitCnt      <= '0;
         r_index       <= '0;
         r_overflow    <= 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
         r_seenNonZero <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (price_bin > PRICE_W'(MAX_VAL)) begin
                     r_operand  <= PRICE_W'(MAX_VAL);
                     r_overflow <= 1'b1;
                  end else begin
                     r_operand  <= price_bin;
                     r_overflow <= 1'b0;
                  end
                  r_bcd    <= '0;
                  r_bitCnt <= CNT_W'(PRICE_W - 1);
`ifdef LEAD_ZERO_BLANK_EN
                  r_seenNonZero <= 1'b0;
`endif
               end
            end
            SHIFT: begin
               {r_bcd, r_operand} <= {w_adjBcd, r_operand} << 1;
               r_bitCnt           <= r_bitCnt - CNT_W'(1);
               r_index            <= IDX_W'(NDIG - 1);
            end
            WRITE: begin
               r_index <= r_index - IDX_W'(1);
`ifdef LEAD_ZERO_BLANK_EN
               if (w_digit != '0) begin
                  r_seenNonZero <= 1'b1;
               end
`endif
               if (r_index == '0) begin
                  r_bcdOut <= r_bcd;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_price_char_encoder.sv
// Self-checking bench for price_char_encoder: table of directed conversions
// plus hand-written sequences for ignored starts, held start and reset abort.
module tb_price_char_encoder;

   logic        CLK;
   logic        RST;
   logic        start;
   logic [16:0] price_bin;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [19:0] bcd_out;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [6:0]  wr_char;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [16:0] price;
      logic [34:0] plain;
      logic [34:0] blank;
      logic [19:0] bcd;
      logic        ovf;
   } vec_t;

   vec_t vecs [8];

   price_char_encoder dut (
      .CLK       (CLK),
      .RST       (RST),
      .start     (start),
      .price_bin (price_bin),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .bcd_out   (bcd_out),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_char   (wr_char)
   );

   // Free-running 10-unit clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_busy"},     32'(busy),     32'd0);
      checkOutput({tag, "_done"},     32'(done),     32'd0);
      checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
      checkOutput({tag, "_bcd"},      32'(bcd_out),  32'd0);
      checkOutput({tag, "_wr_en"},    32'(wr_en),    32'd0);
      checkOutput({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
      checkOutput({tag, "_wr_char"},  32'(wr_char),  32'h20);
   endtask

   // Starts a conversion at the current negedge (accepted on the next edge)
   // and watches cycles 1..23; optional start pulses at cycles pulseA/pulseB
   task automatic applyStimulus(input string name, input logic [16:0] price,
                                input logic [34:0] plain, input logic [34:0] blank,
                                input logic [19:0] expBcd, input logic expOvf,
                                input bit holdStart, input int pulseA, input int pulseB);
      int writes  = 0;
      int doneCnt = 0;
      int doneCyc = 0;
      int busyErr = 0;
      logic [34:0] expChars;
      logic [34:0] shifted;
`ifdef LEAD_ZERO_BLANK_EN
      expChars = blank;
`else
      expChars = plain;
`endif
      start     = 1'b1;
      price_bin = price;
      for (int k = 1; k <= 23; k++) begin
         @(negedge CLK);
         if (wr_en) begin
            if (writes < 5) begin
               shifted = expChars << (7 * writes);
               checkOutput($sformatf("%s_addr%0d", name, writes), 32'(wr_addr), 32'(writes));
               checkOutput($sformatf("%s_char%0d", name, writes), 32'(wr_char), 32'(shifted[34:28]));
               checkOutput($sformatf("%s_wcyc%0d", name, writes), 32'(k), 32'(18 + writes));
            end
            writes++;
         end
         if (done) begin
            doneCnt++;
            doneCyc = k;
            checkOutput({name, "_busy_at_done"}, 32'(busy),     32'd0);
            checkOutput({name, "_bcd"},          32'(bcd_out),  32'(expBcd));
            checkOutput({name, "_overflow"},     32'(overflow), 32'(expOvf));
         end
         if (k <= 22 && !busy) busyErr++;
         if (k == 1 && !holdStart) start = 1'b0;
         if (k == pulseA || k == pulseB) begin
            start     = 1'b1;
            price_bin = 17'd5;
         end else if (k == pulseA + 1 || k == pulseB + 1) begin
            start = holdStart;
         end
      end
      checkOutput({name, "_writes"},    32'(writes),  32'd5);
      checkOutput({name, "_done_cnt"},  32'(doneCnt), 32'd1);
      checkOutput({name, "_done_cyc"},  32'(doneCyc), 32'd23);
      checkOutput({name, "_busy_gaps"}, 32'(busyErr), 32'd0);
   endtask

   // Watches n idle cycles and expects no writes, no done and no busy
   task automatic idleWatch(input string name, input int n);
      int we = 0;
      int dn = 0;
      int bz = 0;
      repeat (n) begin
         @(negedge CLK);
         if (wr_en) we++;
         if (done)  dn++;
         if (busy)  bz++;
      end
      checkOutput({name, "_no_wr"},   32'(we), 32'd0);
      checkOutput({name, "_no_done"}, 32'(dn), 32'd0);
      checkOutput({name, "_no_busy"}, 32'(bz), 32'd0);
   endtask

   initial begin
      vecs[0] = '{17'd12345,  {7'h31,7'h32,7'h33,7'h34,7'h35}, {7'h31,7'h32,7'h33,7'h34,7'h35}, 20'h12345, 1'b0};
      vecs[1] = '{17'd0,      {7'h30,7'h30,7'h30,7'h30,7'h30}, {7'h20,7'h20,7'h20,7'h20,7'h30}, 20'h00000, 1'b0};
      vecs[2] = '{17'd100000, {7'h39,7'h39,7'h39,7'h39,7'h39}, {7'h39,7'h39,7'h39,7'h39,7'h39}, 20'h99999, 1'b1};
      vecs[3] = '{17'd7,      {7'h30,7'h30,7'h30,7'h30,7'h37}, {7'h20,7'h20,7'h20,7'h20,7'h37}, 20'h00007, 1'b0};
      vecs[4] = '{17'd99999,  {7'h39,7'h39,7'h39,7'h39,7'h39}, {7'h39,7'h39,7'h39,7'h39,7'h39}, 20'h99999, 1'b0};
      vecs[5] = '{17'd131071, {7'h39,7'h39,7'h39,7'h39,7'h39}, {7'h39,7'h39,7'h39,7'h39,7'h39}, 20'h99999, 1'b1};
      vecs[6] = '{17'd10000,  {7'h31,7'h30,7'h30,7'h30,7'h30}, {7'h31,7'h30,7'h30,7'h30,7'h30}, 20'h10000, 1'b0};
      vecs[7] = '{17'd50,     {7'h30,7'h30,7'h30,7'h35,7'h30}, {7'h20,7'h20,7'h20,7'h35,7'h30}, 20'h00050, 1'b0};

      RST       = 1'b1;
      start     = 1'b0;
      price_bin = '0;
      repeat (2) @(negedge CLK);
      checkResetState("por");
      RST = 1'b0;
      @(negedge CLK);

      for (int i = 0; i < 8; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].price, vecs[i].plain, vecs[i].blank,
                       vecs[i].bcd, vecs[i].ovf, 1'b0, 0, 0);
         @(negedge CLK);
         checkOutput($sformatf("vec%0d_ovf_hold", i), 32'(overflow), 32'(vecs[i].ovf));
      end

      // Start pulses during a busy conversion must be ignored
      applyStimulus("pulses", 17'd12345,
                    {7'h31,7'h32,7'h33,7'h34,7'h35}, {7'h31,7'h32,7'h33,7'h34,7'h35},
                    20'h12345, 1'b0, 1'b0, 3, 22);
      idleWatch("pulses_after", 6);

      // Held start: second conversion accepted in the first idle cycle after done
      applyStimulus("held1", 17'd2024,
                    {7'h30,7'h32,7'h30,7'h32,7'h34}, {7'h20,7'h32,7'h30,7'h32,7'h34},
                    20'h02024, 1'b0, 1'b1, 0, 0);
      @(negedge CLK);
      checkOutput("held_gap_busy", 32'(busy), 32'd0);
      checkOutput("held_gap_done", 32'(done), 32'd0);
      applyStimulus("held2", 17'd31,
                    {7'h30,7'h30,7'h30,7'h33,7'h31}, {7'h20,7'h20,7'h20,7'h33,7'h31},
                    20'h00031, 1'b0, 1'b0, 0, 0);
      @(negedge CLK);

      // Reset during SHIFT aborts the conversion immediately
      start     = 1'b1;
      price_bin = 17'd100000;
      for (int k = 1; k <= 10; k++) begin
         @(negedge CLK);
         if (k == 1) start = 1'b0;
      end
      checkOutput("pre_abort_busy", 32'(busy), 32'd1);
      RST = 1'b1;
      #1;
      checkResetState("abort");
      @(negedge CLK);
      RST = 1'b0;
      idleWatch("abort_after", 30);
      applyStimulus("after_rst", 17'd907,
                    {7'h30,7'h30,7'h39,7'h30,7'h37}, {7'h20,7'h20,7'h39,7'h30,7'h37},
                    20'h00907, 1'b0, 1'b0, 0, 0);
      @(negedge CLK);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
